alu_share_arbiter: RTL and testbench

//   Shares one combinational ALU (ADD/SUB/AND/OR, NZCV flags) between two requesters.

---
 rtl/alu_share_arbiter_if.sv | 50 +++++
 rtl/alu_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundle of the two request channels, the response channel and the
//   connection to the shared combinational ALU.
//   slave  : the arbiter's view.
//   master : the surrounding environment (requesters, consumer, ALU).
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_ctrl;

  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [1:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  alu_result, alu_flags, rsp_ready,
    output req0_ready, req1_ready,
    output alu_srca, alu_srcb, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output alu_result, alu_flags, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_srca, alu_srcb, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters.
//   IDLE -> EXEC -> RESP -> IDLE, one operation per three cycles at best.
//   Operands are registered at accept and presented to the ALU only during
//   EXEC; result and flags are captured at the end of EXEC and held until
//   the consumer takes them.
//   Configuration macro: ALU_ARB_FIXED_PRIO_EN
//     undefined (default) : round-robin between the requesters
//     defined             : req0 always wins a tie (req1 can starve)
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e           state_r;
  state_e           next_state_s;

  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic             rsp_done_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       ctrl_r;
  logic             id_r;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic [3:0]       rsp_flags_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_id_r;
`endif

  assign accept_s   = grant0_s | grant1_s;
  assign rsp_done_s = (state_r == ST_RESP) & bus.rsp_ready;

  // Arbitration: pick at most one valid requester, only while IDLE
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == ST_IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant1_s = bus.req1_valid & ~bus.req0_valid;
`else
      // On a tie the requester that did not go last wins
      grant1_s = bus.req1_valid & (~bus.req0_valid | ~last_id_r);
`endif
      grant0_s = bus.req0_valid & ~grant1_s;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: next_state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: readies mirror the grant
  always_comb begin
    bus.req0_ready = grant0_s;
    bus.req1_ready = grant1_s;
  end

  // Operand registers: loaded on accept, cleared after EXEC so the ALU sees ADD 0+0 otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      ctrl_r <= 2'b00;
      id_r   <= 1'b0;
    end else if (accept_s) begin
      a_r    <= grant1_s ? bus.req1_a    : bus.req0_a;
      b_r    <= grant1_s ? bus.req1_b    : bus.req0_b;
      ctrl_r <= grant1_s ? bus.req1_ctrl : bus.req0_ctrl;
      id_r   <= grant1_s;
    end else if (state_r == ST_EXEC) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      ctrl_r <= 2'b00;
      id_r   <= id_r;
    end else begin
      a_r    <= a_r;
      b_r    <= b_r;
      ctrl_r <= ctrl_r;
      id_r   <= id_r;
    end
  end

  // Response registers: capture ALU output at end of EXEC, hold until consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_flags_r  <= 4'b0000;
    end else if (state_r == ST_EXEC) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= id_r;
      rsp_result_r <= bus.alu_result;
      rsp_flags_r  <= bus.alu_flags;
    end else if (rsp_done_s) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= rsp_id_r;
      rsp_result_r <= rsp_result_r;
      rsp_flags_r  <= rsp_flags_r;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
      rsp_id_r     <= rsp_id_r;
      rsp_result_r <= rsp_result_r;
      rsp_flags_r  <= rsp_flags_r;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin history: remember who was served last (req0 wins the first tie)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_id_r <= 1'b1;
    end else if (accept_s) begin
      last_id_r <= grant1_s;
    end else begin
      last_id_r <= last_id_r;
    end
  end
`endif

  assign bus.alu_srca   = a_r;
  assign bus.alu_srcb   = b_r;
  assign bus.alu_ctrl   = ctrl_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_flags  = rsp_flags_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed and randomized operations against a behavioural ALU and an
//   arithmetic reference model of the arbiter.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic last_id_m;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the arbiter's ALU port
  logic [W:0]   sum_s;
  logic [W-1:0] bop_s;
  always_comb begin
    bop_s = bus.alu_ctrl[0] ? ~bus.alu_srcb : bus.alu_srcb;
    sum_s = {1'b0, bus.alu_srca} + {1'b0, bop_s} + {{W{1'b0}}, bus.alu_ctrl[0]};
    case (bus.alu_ctrl)
      2'b10:   bus.alu_result = bus.alu_srca & bus.alu_srcb;
      2'b11:   bus.alu_result = bus.alu_srca | bus.alu_srcb;
      default: bus.alu_result = sum_s[W-1:0];
    endcase
    bus.alu_flags[3] = bus.alu_result[W-1];
    bus.alu_flags[2] = (bus.alu_result == {W{1'b0}});
    bus.alu_flags[1] = ~bus.alu_ctrl[1] & sum_s[W];
    bus.alu_flags[0] = ~bus.alu_ctrl[1] & ~(bus.alu_srca[W-1] ^ bus.alu_srcb[W-1] ^ bus.alu_ctrl[0])
                       & (bus.alu_srca[W-1] ^ sum_s[W-1]);
  end

  // Reference result {flags, result} from plain integer arithmetic
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    longint sa, sb, sr, ua, ub;
    logic [31:0] r;
    logic cf, vf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      2'b00: begin
        r  = a + b;
        cf = (ua + ub) > 64'sd4294967295;
        sr = sa + sb;
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b01: begin
        r  = a - b;
        cf = (ua >= ub);
        sr = sa - sb;
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'h0), cf, vf, r};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE back to IDLE, with optional response backpressure
  task automatic issue(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] c0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] c1,
                       input logic exp_id, input logic [31:0] exp_res, input logic [3:0] exp_flg,
                       input int stall, input string tag);
    logic [31:0] sa, sb;
    logic [1:0]  sc;
    sa = exp_id ? a1 : a0;
    sb = exp_id ? b1 : b0;
    sc = exp_id ? c1 : c0;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1;
    bus.rsp_ready  = 1'b0;
    #1;
    chk({tag, "_grant"}, {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, exp_id, ~exp_id});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, "_exec_alu"}, {bus.alu_ctrl, bus.alu_srca, bus.alu_srcb[29:0]}, {sc, sa, sb[29:0]});
    chk({tag, "_exec_idle"}, {61'd0, bus.rsp_valid, bus.req1_ready, bus.req0_ready}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_rsp"}, {26'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_result},
        {26'd0, 1'b1, exp_id, exp_flg, exp_res});
    chk({tag, "_resp_alu0"}, {30'd0, bus.alu_ctrl, bus.alu_srca}, 64'd0);
    for (int i = 0; i < stall; i++) begin
      bus.req0_valid = 1'b1; bus.req0_a = $urandom;
      bus.req1_valid = 1'b1; bus.req1_a = $urandom;
      #1;
      chk({tag, "_stall_rdy"}, {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      @(posedge clk); #1;
      chk({tag, "_stall_hold"}, {26'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_result},
          {26'd0, 1'b1, exp_id, exp_flg, exp_res});
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready  = 1'b0;
    chk({tag, "_consumed"}, {63'd0, bus.rsp_valid}, 64'd0);
    last_id_m = exp_id;
  endtask

  initial begin
    logic        v0, v1, eid;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  c0, c1;
    logic [35:0] rr;
    logic [3:0]  exp_ids;

    reset_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = 32'h0; bus.req0_b = 32'h0; bus.req0_ctrl = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_a = 32'h0; bus.req1_b = 32'h0; bus.req1_ctrl = 2'b00;
    bus.rsp_ready  = 1'b0;
    last_id_m = 1'b1;
    #12;
    chk("reset_rsp", {26'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_result}, 64'd0);
    chk("reset_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    chk("reset_alu", {bus.alu_ctrl, bus.alu_srca, bus.alu_srcb[29:0]}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    issue(1'b1, 32'd5, 32'd3, 2'b00, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 32'd8, 4'b0000, 0, "add5_3");
    issue(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 32'd3, 32'd3, 2'b01, 1'b1, 32'd0, 4'b0110, 0, "sub3_3");
    issue(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 32'd0, 32'd1, 2'b01, 1'b1, 32'hFFFF_FFFF, 4'b1000, 5, "sub0_1_bp");
    issue(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 1'b0, 32'd0, 32'd0, 2'b00,
          1'b0, 32'h00F0_00F0, 4'b0000, 0, "and");
    issue(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, 1'b0, 32'd0, 32'd0, 2'b00,
          1'b0, 32'hFFF0_FFF0, 4'b1000, 2, "or");

    // Reset while the op is in EXEC: the op is dropped
    bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd4; bus.req1_ctrl = 2'b00;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    chk("rst_exec_pre", {32'd0, bus.alu_srca}, 64'd9);
    reset_n = 1'b0;
    #1;
    chk("rst_exec_clear", {31'd0, bus.rsp_valid, bus.alu_srca}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
    last_id_m = 1'b1;

    // Both requesters valid back to back
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = 4'b0000;
`else
    exp_ids = 4'b1010;
`endif
    for (int i = 0; i < 4; i++) begin
      eid = exp_ids[i];
      issue(1'b1, 32'd10, 32'd20, 2'b00, 1'b1, 32'd7, 32'd9, 2'b01, eid,
            eid ? 32'hFFFF_FFFE : 32'd30, eid ? 4'b1000 : 4'b0000, 0, "tie");
    end

    // Randomized operations against the reference model
    for (int n = 0; n < 30; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = pick_val(); b0 = pick_val(); c0 = 2'($urandom_range(0, 3));
      a1 = pick_val(); b1 = pick_val(); c1 = 2'($urandom_range(0, 3));
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        eid = 1'b0;
`else
        eid = ~last_id_m;
`endif
      end else begin
        eid = v1;
      end
      rr = eid ? ref_op(a1, b1, c1) : ref_op(a0, b0, c0);
      issue(v0, a0, b0, c0, v1, a1, b1, c1, eid, rr[31:0], rr[35:32],
            int'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
